// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations.
// Results are registered on entry to DONE and held until the next result or reset.
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH-1:0] div_r;

    logic             accept;
    logic             last_step;
    logic             divisor_zero;
    logic [WIDTH:0]   rem_shifted;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH:0]   quo_wide;
    logic [WIDTH-1:0] step_quo;

    assign accept       = start && (state != RUN);
    assign last_step    = (state == RUN) && (count == LAST_STEP);
    assign divisor_zero = (divisor == '0);

    // One restoring step: the extra top bit of the WIDTH+1-bit subtraction is the borrow.
    assign rem_shifted = {part_rem, quo_shift[WIDTH-1]};
    assign trial       = {1'b0, rem_shifted} - {2'b00, div_r};
    assign no_borrow   = ~trial[WIDTH+1];
    assign step_rem    = no_borrow ? trial[WIDTH-1:0] : rem_shifted[WIDTH-1:0];
    assign quo_wide    = {quo_shift, no_borrow};
    assign step_quo    = quo_wide[WIDTH-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            part_rem    <= '0;
            quo_shift   <= '0;
            div_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count     <= '0;
            part_rem  <= '0;
            quo_shift <= dividend;
            div_r     <= divisor;
            // A zero divisor skips RUN and publishes the saturated result immediately.
            if (divisor_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            count     <= count + 1'b1;
            part_rem  <= step_rem;
            quo_shift <= step_quo;
            if (last_step) begin
                quotient    <= step_quo;
                remainder   <= step_rem;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: expected results are queued at start
// and compared when done is seen; latency and busy duration are measured per operation.
module tb_seq_restoring_divider;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic res_t observed();
        res_t o;
        o.q  = quotient;
        o.r  = remainder;
        o.dz = div_by_zero;
        return o;
    endfunction

    // Called at a falling edge; the next rising edge is the start edge. Returns at the
    // falling edge right after it, with the operands scrambled to prove they were captured.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Samples at each falling edge until done; lat counts cycles from the start edge.
    task automatic wait_done(input int budget, output int lat, output int busy_cnt, output bit seen);
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                lat  = n + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [2*WIDTH+2:0] obs;
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        repeat (3) @(negedge clk);
        obs = {busy, done, quotient, remainder, div_by_zero};
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h required 0", obs);
        end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_basic();
        int   lat, bc;
        bit   seen;
        res_t e, o;
        issue(32'd100, 32'd7);
        wait_done(60, lat, bc, seen);
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!seen || o !== e) begin
            n_bad++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dz=%0d seen=%0d required q=%0d r=%0d dz=%0d",
                     o.q, o.r, o.dz, seen, e.q, e.r, e.dz);
        end
        n_cmp++;
        if (lat !== WIDTH + 1) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d required %0d", lat, WIDTH + 1);
        end
        n_cmp++;
        if (bc !== WIDTH) begin
            n_bad++;
            $display("FAIL basic_busy_cycles: got %0d required %0d", bc, WIDTH);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = observed();
            n_cmp++;
            if (done !== 1'b0 || o !== e) begin
                n_bad++;
                $display("FAIL basic_hold_%0d: got done=%0d q=%0d r=%0d required done=0 q=%0d r=%0d",
                         i, done, o.q, o.r, e.q, e.r);
            end
        end
    endtask

    task automatic test_extremes();
        int   lat, bc;
        bit   seen;
        res_t e, o;
        logic [WIDTH-1:0] a_list[2];
        logic [WIDTH-1:0] b_list[2];
        a_list = '{32'hFFFF_FFFF, 32'd3};
        b_list = '{32'd1, 32'd10};
        for (int i = 0; i < 2; i++) begin
            issue(a_list[i], b_list[i]);
            wait_done(60, lat, bc, seen);
            e = sb.pop_front();
            o = observed();
            n_cmp++;
            if (!seen || o !== e || lat !== WIDTH + 1) begin
                n_bad++;
                $display("FAIL extreme_%0d: got q=%h r=%h dz=%0d lat=%0d required q=%h r=%h dz=%0d lat=%0d",
                         i, o.q, o.r, o.dz, lat, e.q, e.r, e.dz, WIDTH + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_by_zero();
        int   lat, bc;
        bit   seen;
        res_t e, o;
        issue(32'd5, 32'd0);
        wait_done(60, lat, bc, seen);
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!seen || o !== e) begin
            n_bad++;
            $display("FAIL div0_result: got q=%h r=%0d dz=%0d seen=%0d required q=%h r=%0d dz=%0d",
                     o.q, o.r, o.dz, seen, e.q, e.r, e.dz);
        end
        n_cmp++;
        if (lat !== 1 || bc !== 0) begin
            n_bad++;
            $display("FAIL div0_timing: got lat=%0d busy=%0d required lat=1 busy=0", lat, bc);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || o !== observed()) begin
            n_bad++;
            $display("FAIL div0_after: got busy=%0d done=%0d required busy=0 done=0 with held result",
                     busy, done);
        end
    endtask

    task automatic test_busy_ignore();
        int   lat, bc;
        bit   seen;
        res_t e, o;
        issue(32'd1000, 32'd10);
        repeat (9) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, lat, bc, seen);
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!seen || o !== e || lat + 10 !== WIDTH + 1) begin
            n_bad++;
            $display("FAIL busy_ignore: got q=%0d r=%0d lat=%0d required q=%0d r=%0d lat=%0d",
                     o.q, o.r, lat + 10, e.q, e.r, WIDTH + 1);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore_no_restart: got busy=%0d done=%0d required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int   lat, bc;
        bit   seen;
        int   early_done;
        res_t e, o;
        logic [2*WIDTH+2:0] obs;
        issue(32'd50, 32'd5);
        early_done = 0;
        for (int n = 0; n < 14; n++) begin
            if (done) early_done++;
            @(negedge clk);
        end
        rst = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        obs = {busy, done, quotient, remainder, div_by_zero};
        n_cmp++;
        if (obs !== '0 || early_done !== 0) begin
            n_bad++;
            $display("FAIL reset_abort: got outputs=%h early_done=%0d required 0 0", obs, early_done);
        end
        rst = 1'b0;
        issue(32'd50, 32'd5);
        wait_done(60, lat, bc, seen);
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!seen || o !== e || lat !== WIDTH + 1) begin
            n_bad++;
            $display("FAIL after_reset_50_5: got q=%0d r=%0d lat=%0d required q=%0d r=%0d lat=%0d",
                     o.q, o.r, lat, e.q, e.r, WIDTH + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   lat, bc;
        bit   seen;
        res_t e, o;
        issue(32'd20, 32'd6);
        wait_done(60, lat, bc, seen);
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!seen || o !== e) begin
            n_bad++;
            $display("FAIL b2b_first: got q=%0d r=%0d required q=%0d r=%0d", o.q, o.r, e.q, e.r);
        end
        issue(32'd7, 32'd2);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: got done=%0d busy=%0d required done=0 busy=1", done, busy);
        end
        wait_done(60, lat, bc, seen);
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!seen || o !== e || lat !== WIDTH + 1 || bc !== WIDTH) begin
            n_bad++;
            $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d busy=%0d required q=%0d r=%0d lat=%0d busy=%0d",
                     o.q, o.r, lat, bc, e.q, e.r, WIDTH + 1, WIDTH);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int   lat, bc;
        bit   seen;
        res_t e, o;
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? WIDTH'($urandom_range(1, 1000)) : $urandom >> $urandom_range(0, 31);
            issue(a, b);
            wait_done(60, lat, bc, seen);
            e = sb.pop_front();
            o = observed();
            n_cmp++;
            if (!seen || o !== e) begin
                n_bad++;
                $display("FAIL random_%0d %h/%h: got q=%h r=%h dz=%0d required q=%h r=%h dz=%0d",
                         i, a, b, o.q, o.r, o.dz, e.q, e.r, e.dz);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
